mem_access_stage: RTL

// - MEM stage between ex_mem_register and the MEM/WB boundary. Consumes the ex_mem_register outputs.
// - Runs a req/ack handshake with a multi-cycle data memory and stalls the pipeline while an access is outstanding.
// - Resolves beq-style branches against the fetch prediction and issues flush/redirect plus a predictor update.
// - Registers the results into MEM/WB (built-in) and keeps branch/mispredict performance counters.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_access_stage_perf_counters.sv | 24 ++
 rtl/mem_access_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: datapath width, FSM encoding, PC step.
package mem_pkg;

   localparam int XLEN = 64;

   localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_access_stage_perf_counters.sv
// Branch and mispredict event counters; both wrap modulo 2^CNT_W.
module perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             branch_evt,
   input  logic             mispred_evt,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (en) begin
         branch_cnt  <= branch_cnt  + {{(CNT_W-1){1'b0}}, branch_evt};
         mispred_cnt <= mispred_cnt + {{(CNT_W-1){1'b0}}, mispred_evt};
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory handshake with stall, branch resolution,
// MEM/WB register and performance counters.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  pc_value,
   input  logic [XLEN-1:0]  pc_plus_imm,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [XLEN-1:0]  rd2,
   input  logic [4:0]       rd,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             memToReg,
   input  logic             branch,
   input  logic             reg_write,
   input  logic             zero,
   input  logic             prediction,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [XLEN-1:0]  dmem_addr,
   output logic [XLEN-1:0]  dmem_wdata,
   input  logic             dmem_ack,
   input  logic [XLEN-1:0]  dmem_rdata,
   output logic             stall,
   output logic             flush,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             bp_update,
   output logic             bp_taken,
   output logic [4:0]       wb_rd,
   output logic             wb_reg_write,
   output logic [XLEN-1:0]  wb_data,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt,
   output logic             mem_timeout
);

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   mem_state_e      state;
   logic [7:0]      wait_cnt;
   logic [XLEN-1:0] load_data;
   logic            timed_out;
   logic            mem_op;
   logic            resolve_en;
   logic            taken;

   assign mem_op     = mem_read | mem_write;
   assign stall      = ((state == IDLE) && mem_op) || (state == ACCESS);
   assign resolve_en = ~stall;

   // The request is live exactly while the stage is stalled on memory.
   assign dmem_req   = stall;
   assign dmem_we    = mem_write;
   assign dmem_addr  = alu_result;
   assign dmem_wdata = rd2;

   assign taken       = branch & zero;
   assign flush       = resolve_en & branch & (taken != prediction);
   assign redirect_pc = taken ? pc_plus_imm : pc_value + PC_INC;
   assign bp_update   = resolve_en & branch;
   assign bp_taken    = resolve_en & taken;

   // NOTE: state is assigned with <= so every reader in this block sees the
   // pre-edge value; blocking here would race against the MEM/WB update below.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         // NOTE: load_data is a single register, not a memory array, so it is
         // reset along with everything else.
         load_data    <= '0;
         timed_out    <= 1'b0;
         mem_timeout  <= 1'b0;
         wb_rd        <= '0;
         wb_reg_write <= 1'b0;
         wb_data      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op && !flush) begin
                  state    <= ACCESS;
                  wait_cnt <= '0;
               end
            end
            ACCESS: begin
               if (dmem_ack) begin
                  load_data <= dmem_rdata;
                  state     <= DONE;
               end else if (wait_cnt == TIMEOUT_LAST) begin
                  load_data   <= '0;
                  timed_out   <= 1'b1;
                  mem_timeout <= 1'b1;
                  state       <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            DONE: begin
               // One idle-free cycle lets EX/MEM advance before a new access.
               timed_out <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (stall) begin
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
         end else begin
            wb_rd        <= rd;
            wb_reg_write <= reg_write;
            wb_data      <= timed_out ? '0 : (memToReg ? load_data : alu_result);
         end
      end
   end

   perf_counters #(.CNT_W(CNT_W)) u_perf (
      .clk         (clk),
      .reset       (reset),
      .en          (resolve_en),
      .branch_evt  (branch),
      .mispred_evt (flush),
      .branch_cnt  (branch_cnt),
      .mispred_cnt (mispred_cnt)
   );

endmodule
